// File: rtl/fp_reduce_pkg.sv
// Shared types, constants and FP16 arithmetic for the column reducer.
// addfp16 is IEEE-754 binary16 addition, round-to-nearest-even, with subnormals and canonical NaN 16'h7E00.
package fp_reduce_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [4:0]  FP16_EXP_MAX  = 5'h1F;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;

  function automatic int tree_levels(input int n);
    int lvl;
    int cap;
    lvl = 0;
    cap = 1;
    for (int i = 0; i < 32; i++) begin
      if (cap < n) begin
        cap = cap * 2;
        lvl = lvl + 1;
      end
    end
    return lvl;
  endfunction

  function automatic int level_count(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic logic [15:0] addfp16(input logic [15:0] a, input logic [15:0] b);
    logic        a_inf, b_inf, a_nan, b_nan, sub, rnd;
    logic [15:0] x, y, res;
    logic [4:0]  ex, ey;
    logic [10:0] mx, my;
    logic [43:0] bx, by, r;
    logic [42:0] n;
    logic [11:0] m;
    int          e, p, lz, sh;
    a_inf = (a[14:10] == FP16_EXP_MAX) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == FP16_EXP_MAX) && (b[9:0] == 10'd0);
    a_nan = (a[14:10] == FP16_EXP_MAX) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == FP16_EXP_MAX) && (b[9:0] != 10'd0);
    res = FP16_POS_ZERO;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      res = FP16_QNAN;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else begin
      if (a[14:0] >= b[14:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      ex  = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
      ey  = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
      mx  = {x[14:10] != 5'd0, x[9:0]};
      my  = {y[14:10] != 5'd0, y[9:0]};
      sub = x[15] ^ y[15];
      // 32 spare fraction bits keep the aligned sum exact; rounding happens once below
      bx = {1'b0, mx, 32'd0};
      by = {1'b0, my, 32'd0} >> (ex - ey);
      r  = sub ? (bx - by) : (bx + by);
      if (r == 44'd0) begin
        res = {~sub & x[15], 15'd0};
      end else begin
        e = int'(ex);
        if (r[43]) begin
          n = 43'(r >> 1);
          e = e + 1;
        end else begin
          p = 0;
          for (int i = 0; i < 43; i++) if (r[i]) p = i;
          lz = 42 - p;
          sh = (lz < e - 1) ? lz : e - 1;
          n  = 43'(r << sh);
          e  = e - sh;
          if (!n[42]) e = 0;
        end
        rnd = n[31] & ((|n[30:0]) | n[32]);
        m   = {1'b0, n[42:32]} + {11'd0, rnd};
        if (m[11]) begin
          m = m >> 1;
          e = e + 1;
        end else if ((e == 0) && m[10]) begin
          e = 1;
        end
        if (e >= 31) res = {x[15], FP16_EXP_MAX, 10'd0};
        else         res = {x[15], 5'(e), m[9:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_column_reducer_tree_level.sv
// One registered level of the addfp16 reduction tree: adjacent pairs summed, odd tail paired with +0.
module fp_tree_level
  import fp_reduce_pkg::*;
#(
  parameter int IN_COUNT   = 2,
  parameter int DATA_WIDTH = 16,
  localparam int OUT_COUNT = (IN_COUNT + 1) / 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid_in,
  input  logic [IN_COUNT-1:0][DATA_WIDTH-1:0]  data_in,
  output logic                                 valid_out,
  output logic [OUT_COUNT-1:0][DATA_WIDTH-1:0] data_out
);

  logic [2*OUT_COUNT-1:0][DATA_WIDTH-1:0] padded;
  logic [OUT_COUNT-1:0][DATA_WIDTH-1:0]   sums;

  if (2 * OUT_COUNT != IN_COUNT) begin : g_pad
    assign padded = {FP16_POS_ZERO, data_in};
  end else begin : g_even
    assign padded = data_in;
  end

  always_comb begin
    sums = '0;
    for (int i = 0; i < OUT_COUNT; i++) sums[i] = addfp16(padded[2*i], padded[2*i+1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) data_out <= sums;
    end
  end

endmodule

// File: rtl/fp_column_reducer.sv
// FP16 frame reducer: per-column addfp16 tree, cross-column accumulator, valid/ready result port.
// Optional sum_special status output enabled by FP_REDUCE_STATUS_EN.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for first column
// ACCUM  | accepting remaining columns of the frame
// DRAIN  | all columns taken, waiting for the last tree result
// OUTPUT | sum presented, waiting for downstream handshake
module fp_column_reducer
  import fp_reduce_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAT_HEIGHT = 4,
  parameter int NUM_COLS   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_in,
  output logic                                  ready_in,
  input  logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] column,
  output logic                                  valid_out,
  input  logic                                  ready_out,
  output logic [DATA_WIDTH-1:0]                 sum
`ifdef FP_REDUCE_STATUS_EN
  ,
  output logic                                  sum_special
`endif
);

  localparam int TREE_LAT = tree_levels(MAT_HEIGHT);
  localparam int CNT_W    = $clog2(NUM_COLS + 1);

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("fp_column_reducer supports only DATA_WIDTH=16");
  end
  if (MAT_HEIGHT < 1 || NUM_COLS < 1) begin : g_bad_dims
    $error("fp_column_reducer needs MAT_HEIGHT>=1 and NUM_COLS>=1");
  end

  state_t                                state, state_nxt;
  logic                                  accept;
  logic [CNT_W-1:0]                      col_cnt, res_cnt;
  logic                                  res_last;
  logic [MAT_HEIGHT-1:0][DATA_WIDTH-1:0] lvl0_data;
  logic                                  lvl0_valid;
  logic [DATA_WIDTH-1:0]                 tree_out, acc, acc_add, last_sum;
  logic                                  tree_vld;

  assign accept = valid_in && ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl0_valid <= 1'b0;
      lvl0_data  <= '0;
    end else begin
      lvl0_valid <= accept;
      if (accept) lvl0_data <= column;
    end
  end

  for (genvar k = 0; k < TREE_LAT; k++) begin : g_lvl
    localparam int IN_N  = level_count(MAT_HEIGHT, k);
    localparam int OUT_N = level_count(MAT_HEIGHT, k + 1);
    logic [IN_N-1:0][DATA_WIDTH-1:0]  d_in;
    logic [OUT_N-1:0][DATA_WIDTH-1:0] d_out;
    logic                             v_in, v_out;
    if (k == 0) begin : g_src
      assign d_in = lvl0_data;
      assign v_in = lvl0_valid;
    end else begin : g_src
      assign d_in = g_lvl[k-1].d_out;
      assign v_in = g_lvl[k-1].v_out;
    end
    fp_tree_level #(
      .IN_COUNT   (IN_N),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (v_in),
      .data_in   (d_in),
      .valid_out (v_out),
      .data_out  (d_out)
    );
  end

  if (TREE_LAT == 0) begin : g_no_tree
    assign tree_out = lvl0_data[0];
    assign tree_vld = lvl0_valid;
  end else begin : g_tree_out
    assign tree_out = g_lvl[TREE_LAT-1].d_out[0];
    assign tree_vld = g_lvl[TREE_LAT-1].v_out;
  end

  // first column loads acc directly so a lone -0 keeps its sign
  assign acc_add  = addfp16(acc, tree_out);
  assign res_last = (res_cnt == CNT_W'(NUM_COLS - 1));
  assign last_sum = (res_cnt == '0) ? tree_out : acc_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_in  = 1'b0;
    case (state)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) state_nxt = (NUM_COLS == 1) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        ready_in = 1'b1;
        if (valid_in && (col_cnt == CNT_W'(NUM_COLS - 1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tree_vld && res_last) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (valid_out && ready_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      res_cnt   <= '0;
      acc       <= '0;
      sum       <= '0;
      valid_out <= 1'b0;
    end else begin
      if (accept) col_cnt <= col_cnt + CNT_W'(1);
      if (tree_vld) begin
        if (res_last) begin
          sum       <= last_sum;
          valid_out <= 1'b1;
          res_cnt   <= '0;
        end else begin
          acc     <= last_sum;
          res_cnt <= res_cnt + CNT_W'(1);
        end
      end
      if (valid_out && ready_out) begin
        valid_out <= 1'b0;
        col_cnt   <= '0;
      end
    end
  end

`ifdef FP_REDUCE_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_special <= 1'b0;
    end else if (valid_out && ready_out) begin
      sum_special <= 1'b0;
    end else if (tree_vld && res_last) begin
      sum_special <= (last_sum[14:10] == FP16_EXP_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_fp_column_reducer.sv
// Randomized bench for fp_column_reducer against a real-arithmetic FP16 reference model.
module tb_fp_column_reducer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic             a_valid_in, a_ready_in, a_valid_out, a_ready_out;
  logic [3:0][15:0] a_column;
  logic [15:0]      a_sum;
  logic             b_valid_in, b_ready_in, b_valid_out, b_ready_out;
  logic [2:0][15:0] b_column;
  logic [15:0]      b_sum;
`ifdef FP_REDUCE_STATUS_EN
  logic             a_sum_special, b_sum_special;
`endif

  logic [15:0] fa_cols [2][4];
  logic [15:0] fb_col  [3];

  fp_column_reducer #(.DATA_WIDTH(16), .MAT_HEIGHT(4), .NUM_COLS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(a_valid_in), .ready_in(a_ready_in),
    .column(a_column), .valid_out(a_valid_out), .ready_out(a_ready_out), .sum(a_sum)
`ifdef FP_REDUCE_STATUS_EN
    , .sum_special(a_sum_special)
`endif
  );

  fp_column_reducer #(.DATA_WIDTH(16), .MAT_HEIGHT(3), .NUM_COLS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(b_valid_in), .ready_in(b_ready_in),
    .column(b_column), .valid_out(b_valid_out), .ready_out(b_ready_out), .sum(b_sum)
`ifdef FP_REDUCE_STATUS_EN
    , .sum_special(b_sum_special)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_to_real(input logic [15:0] h);
    real r;
    int  ex = int'(h[14:10]);
    int  mt = int'(h[9:0]);
    if (ex == 0) r = real'(mt) * pow2(-24);
    else         r = real'(1024 + mt) * pow2(ex - 25);
    return h[15] ? -r : r;
  endfunction

  // round a nonzero real to FP16, nearest-even
  function automatic logic [15:0] real_to_fp(input real v);
    logic s = (v < 0.0);
    real  a = s ? -v : v;
    real  q, t, fl;
    int   e, im;
    if (a >= 65520.0) return {s, 5'h1F, 10'd0};
    e = -14;
    while (e < 15 && a >= pow2(e + 1)) e++;
    q  = pow2(e - 10);
    t  = a / q;
    fl = $floor(t);
    im = $rtoi(fl);
    if ((t - fl > 0.5) || ((t - fl == 0.5) && (im % 2 == 1))) im++;
    if (im == 2048) begin
      im = 1024;
      e++;
    end
    if (e > 15)    return {s, 5'h1F, 10'd0};
    if (im < 1024) return {s, 5'd0, 10'(im)};
    return {s, 5'(e + 15), 10'(im - 1024)};
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    logic b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    logic a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    logic b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    real  s;
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    s = fp_to_real(a) + fp_to_real(b);
    if (s == 0.0) return {a[15] & b[15], 15'd0};
    return real_to_fp(s);
  endfunction

  function automatic logic [15:0] model_tree(input logic [15:0] vals[$]);
    logic [15:0] cur[$];
    logic [15:0] nxt[$];
    cur = vals;
    while (cur.size() > 1) begin
      nxt.delete();
      for (int i = 0; i < cur.size(); i += 2)
        nxt.push_back(model_add(cur[i], (i + 1 < cur.size()) ? cur[i+1] : 16'h0000));
      cur = nxt;
    end
    return cur[0];
  endfunction

  function automatic logic [15:0] model_frame(input logic [15:0] touts[$]);
    logic [15:0] acc = touts[0];
    for (int i = 1; i < touts.size(); i++) acc = model_add(acc, touts[i]);
    return acc;
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] specials [8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                  16'h0001, 16'h8001, 16'h7BFF, 16'h03FF};
    int mode = int'($urandom_range(0, 3));
    if (mode == 0) return 16'($urandom);
    if (mode == 3) return specials[$urandom_range(0, 7)];
    return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
  endfunction

  task automatic run_frame_a(input string tag, input int gap, input bit early, input int hold);
    logic [15:0] touts[$];
    logic [15:0] q[$];
    logic [15:0] exp_sum;
    int          lat;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) begin
        repeat (gap) begin
          @(negedge clk);
          a_valid_in = 1'b0;
          for (int r = 0; r < 4; r++) a_column[r] = 16'($urandom);
        end
      end
      @(negedge clk);
      a_valid_in  = 1'b1;
      a_ready_out = early;
      for (int r = 0; r < 4; r++) a_column[r] = fa_cols[c][r];
      @(posedge clk);
      #1;
      q.delete();
      for (int r = 0; r < 4; r++) q.push_back(fa_cols[c][r]);
      touts.push_back(model_tree(q));
    end
    exp_sum = model_frame(touts);
    // keep offering a column that must be ignored until the handshake
    for (int r = 0; r < 4; r++) a_column[r] = 16'h4900;
    lat = 0;
    while (!a_valid_out && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, 3);
    chk({tag, ".sum"}, a_sum, exp_sum);
    chk({tag, ".rdy_busy"}, a_ready_in, 0);
`ifdef FP_REDUCE_STATUS_EN
    chk({tag, ".special"}, a_sum_special, exp_sum[14:10] == 5'h1F);
`endif
    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk({tag, ".hold_sum"}, a_sum, exp_sum);
        chk({tag, ".hold_vld"}, a_valid_out, 1);
        chk({tag, ".hold_rdy"}, a_ready_in, 0);
      end
      @(negedge clk);
      a_ready_out = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".vld_drop"}, a_valid_out, 0);
    chk({tag, ".rdy_back"}, a_ready_in, 1);
    @(negedge clk);
    a_valid_in  = 1'b0;
    a_ready_out = 1'b0;
  endtask

  task automatic run_frame_b(input string tag);
    logic [15:0] q[$];
    logic [15:0] exp_sum;
    int          lat;
    @(negedge clk);
    b_valid_in  = 1'b1;
    b_ready_out = 1'b1;
    for (int r = 0; r < 3; r++) b_column[r] = fb_col[r];
    @(posedge clk);
    #1;
    b_valid_in = 1'b0;
    for (int r = 0; r < 3; r++) q.push_back(fb_col[r]);
    exp_sum = model_tree(q);
    lat = 0;
    while (!b_valid_out && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, 3);
    chk({tag, ".sum"}, b_sum, exp_sum);
`ifdef FP_REDUCE_STATUS_EN
    chk({tag, ".special"}, b_sum_special, exp_sum[14:10] == 5'h1F);
`endif
    @(posedge clk);
    #1;
    chk({tag, ".vld_drop"}, b_valid_out, 0);
    chk({tag, ".rdy_back"}, b_ready_in, 1);
    @(negedge clk);
    b_ready_out = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    a_valid_in  = 1'b0;
    a_ready_out = 1'b0;
    a_column    = '0;
    b_valid_in  = 1'b0;
    b_ready_out = 1'b0;
    b_column    = '0;
    #12;
    chk("rst.a_vld", a_valid_out, 0);
    chk("rst.a_rdy", a_ready_in, 1);
    chk("rst.a_sum", a_sum, 16'h0000);
    chk("rst.b_vld", b_valid_out, 0);
    chk("rst.b_rdy", b_ready_in, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 2; c++) begin
      fa_cols[c][0] = 16'h3C00;
      fa_cols[c][1] = 16'h4000;
      fa_cols[c][2] = 16'h4200;
      fa_cols[c][3] = 16'h4400;
    end
    run_frame_a("basic", 0, 1'b0, 2);
    chk("basic.const", a_sum, 16'h4D00);

    for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) fa_cols[c][r] = 16'h3C00;
    run_frame_a("bubble", 3, 1'b0, 1);
    chk("bubble.const", a_sum, 16'h4800);

    for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) fa_cols[c][r] = rand_fp();
    run_frame_a("bp", 0, 1'b0, 5);

    fb_col[0] = 16'h3C00;
    fb_col[1] = 16'h4000;
    fb_col[2] = 16'h4200;
    run_frame_b("odd");
    chk("odd.const", b_sum, 16'h4600);

    for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) fa_cols[c][r] = 16'h7BFF;
    run_frame_a("ovf", 0, 1'b1, 0);
    chk("ovf.const", a_sum, 16'h7C00);

    for (int n = 0; n < 40; n++) begin
      for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) fa_cols[c][r] = rand_fp();
      run_frame_a("rand_a", int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 4)));
    end
    for (int n = 0; n < 20; n++) begin
      for (int r = 0; r < 3; r++) fb_col[r] = rand_fp();
      run_frame_b("rand_b");
    end

    // reset while a result is being presented
    @(negedge clk);
    a_valid_in = 1'b1;
    for (int r = 0; r < 4; r++) a_column[r] = 16'h4900;
    repeat (2) @(posedge clk);
    #1;
    a_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out.pre_vld", a_valid_out, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out.vld", a_valid_out, 0);
    chk("rst_out.rdy", a_ready_in, 1);
    chk("rst_out.sum", a_sum, 16'h0000);
    #1 rst_n = 1'b1;

    // reset with one column of a frame in flight
    @(negedge clk);
    a_valid_in = 1'b1;
    @(posedge clk);
    #1;
    a_valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.vld", a_valid_out, 0);
    chk("rst_mid.rdy", a_ready_in, 1);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) for (int r = 0; r < 4; r++) fa_cols[c][r] = 16'h3C00;
    run_frame_a("rst_after", 0, 1'b0, 1);
    chk("rst_after.const", a_sum, 16'h4800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
